niosii_debug_jtag_host: RTL

NIOSII_DEBUG_JTAG_HOST -- requirements
Module: niosii_debug_jtag_host

---
 rtl/niosii_debug_jtag_host_if.sv | 39 +++
 rtl/niosii_debug_jtag_host.sv | 136 +++++++++++++
 2 files changed

// File: rtl/niosii_debug_jtag_host_if.sv
// Command/response and virtual-JTAG bundle for the Nios II debug JTAG host.
// The host drives the slave modport; the command source and debug slave side use master.
interface niosii_debug_jtag_host_if #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [DR_WIDTH-1:0] cmd_dr;
    logic                abort;
    logic                rsp_valid;
    logic [DR_WIDTH-1:0] rsp_dr;
    logic [IR_WIDTH-1:0] rsp_ir_out;
    logic                vji_tck;
    logic                vji_tdi;
    logic                vji_uir;
    logic                vji_cdr;
    logic                vji_sdr;
    logic                vji_udr;
    logic                vji_rti;
    logic [IR_WIDTH-1:0] vji_ir_in;
    logic                vji_tdo;
    logic [IR_WIDTH-1:0] vji_ir_out;

    modport master (
        output cmd_valid, cmd_ir, cmd_dr, abort, vji_tdo, vji_ir_out,
        input  cmd_ready, rsp_valid, rsp_dr, rsp_ir_out,
        input  vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr,
        input  vji_rti, vji_ir_in
    );

    modport slave (
        input  cmd_valid, cmd_ir, cmd_dr, abort, vji_tdo, vji_ir_out,
        output cmd_ready, rsp_valid, rsp_dr, rsp_ir_out,
        output vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr,
        output vji_rti, vji_ir_in
    );
endinterface

// File: rtl/niosii_debug_jtag_host.sv
// Virtual-JTAG scan host: runs one UIR/CDR/SDR/UDR/RTI sequence per command
// against a Nios II debug slave, with tck derived from clk by a divider.
module niosii_debug_jtag_host #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 4
) (
    input logic clk,
    input logic reset,
    niosii_debug_jtag_host_if.slave bus
);
    localparam int DW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam int BW = $clog2(DR_WIDTH + 1);
    localparam logic [DW-1:0] DIV_TC = DW'(TCK_DIV - 1);
    localparam logic [BW-1:0] BIT_TC = BW'(DR_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI, S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [DW-1:0]       div_q, div_d;
    logic                tck_q, tck_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [DR_WIDTH-1:0] sr_q, sr_d;
    logic                samp_q, samp_d;
    logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
    logic [IR_WIDTH-1:0] ircap_q, ircap_d;
    logic [DR_WIDTH-1:0] rsp_dr_q, rsp_dr_d;
    logic [IR_WIDTH-1:0] rsp_ir_q, rsp_ir_d;

    logic busy, term, rise, fall, accept, done_ok;

    assign busy   = (state_q != S_IDLE) && (state_q != S_DONE);
    assign term   = (div_q == DIV_TC);
    assign rise   = busy && term && !tck_q;
    assign fall   = busy && term && tck_q;
    assign accept = bus.cmd_valid && bus.cmd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            tck_q    <= 1'b0;
            bit_q    <= '0;
            sr_q     <= '0;
            samp_q   <= 1'b0;
            ir_in_q  <= '0;
            ircap_q  <= '0;
            rsp_dr_q <= '0;
            rsp_ir_q <= '0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            tck_q    <= tck_d;
            bit_q    <= bit_d;
            sr_q     <= sr_d;
            samp_q   <= samp_d;
            ir_in_q  <= ir_in_d;
            ircap_q  <= ircap_d;
            rsp_dr_q <= rsp_dr_d;
            rsp_ir_q <= rsp_ir_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = '0;
        tck_d    = 1'b0;
        bit_d    = bit_q;
        sr_d     = sr_q;
        samp_d   = samp_q;
        ir_in_d  = ir_in_q;
        ircap_d  = ircap_q;
        rsp_dr_d = rsp_dr_q;
        rsp_ir_d = rsp_ir_q;
        if (busy) begin
            div_d = term ? '0 : div_q + 1'b1;
            tck_d = term ? ~tck_q : tck_q;
        end
        unique case (state_q)
            S_IDLE: if (accept) begin
                state_d = S_UIR;
                ir_in_d = bus.cmd_ir;
                sr_d    = bus.cmd_dr;
                bit_d   = '0;
            end
            S_UIR: if (fall) state_d = S_CDR;
            S_CDR: begin
                if (rise) ircap_d = bus.vji_ir_out;
                if (fall) state_d = S_SDR;
            end
            S_SDR: begin
                if (rise) samp_d = bus.vji_tdo;
                if (fall) begin
                    sr_d = sr_q >> 1;
                    sr_d[DR_WIDTH-1] = samp_q;
                    bit_d = bit_q + 1'b1;
                    if (bit_q == BIT_TC) state_d = S_UDR;
                end
            end
            S_UDR: if (fall) state_d = S_RTI;
            S_RTI: if (fall) state_d = S_DONE;
            S_DONE: begin
                state_d  = S_IDLE;
                rsp_dr_d = sr_q;
                rsp_ir_d = ircap_q;
            end
            default: state_d = S_IDLE;
        endcase
        // Abort drops the scan without publishing anything it captured.
        if (bus.abort && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            div_d    = '0;
            tck_d    = 1'b0;
            rsp_dr_d = rsp_dr_q;
            rsp_ir_d = rsp_ir_q;
        end
    end

    always_comb begin
        done_ok        = (state_q == S_DONE) && !bus.abort && !reset;
        bus.cmd_ready  = (state_q == S_IDLE) && !bus.abort && !reset;
        bus.vji_tck    = tck_q;
        bus.vji_tdi    = (state_q == S_SDR) && sr_q[0];
        bus.vji_uir    = (state_q == S_UIR);
        bus.vji_cdr    = (state_q == S_CDR);
        bus.vji_sdr    = (state_q == S_SDR);
        bus.vji_udr    = (state_q == S_UDR);
        bus.vji_rti    = (state_q == S_RTI);
        bus.vji_ir_in  = ir_in_q;
        bus.rsp_valid  = done_ok;
        bus.rsp_dr     = done_ok ? sr_q : rsp_dr_q;
        bus.rsp_ir_out = done_ok ? ircap_q : rsp_ir_q;
    end
endmodule
